// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide engine with pipeline stall
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t              state, next_state;
    logic [2:0]          f3_q;
    logic                neg_a, neg_b;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       counter;

    logic                accept, signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_val;
    logic [XLEN:0]       mul_sum, trial;
    logic [XLEN-1:0]     sub;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

    always_comb begin
        accept   = (state == IDLE) && start && !flush;
        signed_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        signed_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        sign_a   = signed_a && op_a[XLEN-1];
        sign_b   = signed_b && op_b[XLEN-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        div_zero = f3[2] && (op_b == '0);
        div_ovf  = f3[2] && !f3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        special  = div_zero || div_ovf;
        // Overflow DIV returns the dividend itself (0x80000000); overflow REM is zero.
        if (div_zero)
            special_val = f3[1] ? op_a : '1;
        else
            special_val = f3[1] ? '0 : op_a;
    end

    // One shift-add step (acc low half holds the multiplier) and one
    // restoring-subtract step (acc = {remainder, dividend/quotient}).
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        trial    = acc[2*XLEN-1:XLEN-1];
        sub      = trial[XLEN-1:0] - opnd;
        if (trial >= {1'b0, opnd})
            div_next = {sub, acc[XLEN-2:0], 1'b1};
        else
            div_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (f3_q[2])
            fix_val = f3_q[1] ? rem_fix : quo_fix;
        else if (f3_q[1:0] == 2'b00)
            fix_val = prod_fix[XLEN-1:0];
        else
            fix_val = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = special ? DONE : CALC;
            CALC:  if (counter == '0) next_state = FIXUP;
            FIXUP: next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
        stall = accept || (state == CALC) || (state == FIXUP);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            f3_q    <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            counter <= '0;
            result  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                f3_q    <= f3;
                neg_a   <= sign_a;
                neg_b   <= sign_b;
                opnd    <= abs_b;
                acc     <= {{XLEN{1'b0}}, abs_a};
                counter <= CW'(XLEN-1);
                if (special) result <= special_val;
            end else if (state == CALC && !flush) begin
                acc     <= f3_q[2] ? div_next : mul_next;
                counter <= counter - 1'b1;
            end else if (state == FIXUP && !flush) begin
                result  <= fix_val;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] result;

    int tests = 0;
    int failed = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res = '0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .f3(f3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: p = ua * ub;
            3'b001: p = sa * sb;
            3'b010: p = sa * ub;
            default: p = ua * ub;
        endcase
        if (!f[2]) return (f == 3'b000) ? p[31:0] : p[63:32];
        if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
        case (f)
            3'b100: return $signed(a) / $signed(b);
            3'b101: return a / b;
            3'b110: return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 34;
    endfunction

    task automatic wait_done(input string tag, input bit drop_start);
        int cycles = 0;
        logic [31:0] e;
        int l;
        do begin
            @(negedge clk);
            cycles++;
            if (drop_start) start = 1'b0;
        end while (!done && cycles < 100);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (!done) begin
            check({tag, "_timeout"}, 32'(done), 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(cycles), 32'(l));
            check(tag, result, e);
            check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        end
        last_res = e;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        f3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        exp_q.push_back(model(f, a, b));
        lat_q.push_back(model_lat(f, a, b));
        wait_done(tag, 1'b1);
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [2:0] rf;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        // Fixed directed ops with hand-derived expectations.
        @(negedge clk);
        f3 = 3'b000; op_a = 32'h7; op_b = 32'hFFFFFFFD; start = 1'b1;
        #1;
        check("mul_stall_accept", 32'(stall), 32'd1);
        exp_q.push_back(32'hFFFFFFEB); lat_q.push_back(34);
        wait_done("mul_7x-3", 1'b1);

        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mulhu_const", last_res, 32'hFFFFFFFE);
        run_op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mulh_const", last_res, 32'h00000000);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mulhsu_const", last_res, 32'hFFFFFFFF);
        run_op("div_-7_2", 3'b100, 32'hFFFFFFF9, 32'd2);
        check("div_const", last_res, 32'hFFFFFFFD);
        run_op("rem_-7_2", 3'b110, 32'hFFFFFFF9, 32'd2);
        check("rem_const", last_res, 32'hFFFFFFFF);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        check("divu_const", last_res, 32'd14);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7);
        check("remu_const", last_res, 32'd2);
        run_op("rem_7_-2", 3'b110, 32'd7, 32'hFFFFFFFE);
        run_op("div_x_0", 3'b100, 32'd5, 32'd0);
        check("div0_const", last_res, 32'hFFFFFFFF);
        run_op("remu_x_0", 3'b111, 32'd9, 32'd0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF);
        check("divovf_const", last_res, 32'h80000000);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb);
        end

        // Flush in the tenth CALC cycle aborts with no done and result unchanged.
        @(negedge clk);
        f3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall_drop", 32'(stall), 32'd0);
        count_done(50, pulses);
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_result_held", result, last_res);

        @(negedge clk);
        f3 = 3'b100; op_a = 32'd1; op_b = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        count_done(5, pulses);
        check("flush_start_no_done", 32'(pulses), 32'd0);
        check("flush_start_result", result, last_res);

        // Back-to-back with start held: second accept right after first DONE.
        @(negedge clk);
        f3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        exp_q.push_back(32'd15); lat_q.push_back(34);
        wait_done("b2b_first", 1'b0);
        op_a = 32'd6; op_b = 32'd7;
        exp_q.push_back(32'd42); lat_q.push_back(35);
        wait_done("b2b_second", 1'b0);
        start = 1'b0;
        count_done(40, pulses);
        check("b2b_extra_done", 32'(pulses), 32'd0);

        // Reset mid-CALC returns all outputs to zero immediately.
        @(negedge clk);
        f3 = 3'b011; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(40, pulses);
        check("rstmid_no_done", 32'(pulses), 32'd0);

        run_op("post_rst_mul", 3'b000, 32'd12, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
